ts_tick_sequencer: RTL and testbench
====================================

TS_TICK_SEQUENCER -- requirements
Module: ts_tick_sequencer

Interface
REQ-001 SHALL have parameter PERIOD, default 10: clocks per tick, legal range 1..255.
REQ-002 SHALL have parameter NUM_TICKS, default 4: ticks per run, legal range 1..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 8: width of tick_cnt.
REQ-004 SHALL have port clock, input, 1 bit: the only clock, rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: run request, sampled in IDLE or DONE only.
REQ-007 SHALL have port abort, input, 1 bit: cancels a run, sampled in any state.
REQ-008 SHALL have port tick, output, 1 bit: registered one-clock pulse per elapsed PERIOD.
REQ-009 SHALL have port tick_cnt, output, CNT_W bits: ticks issued in the current or last run.
REQ-010 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-011 SHALL have port done, output, 1 bit: high while in DONE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE), both registered.
REQ-013 SHALL move IDLE->RUN on edge k with start=1, abort=0, clearing prescaler and tick_cnt to 0 at that edge.
REQ-014 SHALL, in RUN, increment the prescaler each clock and wrap it from PERIOD-1 to 0.
REQ-015 SHALL assert tick for exactly one clock after edges k+PERIOD, k+2*PERIOD, ..., k+NUM_TICKS*PERIOD.
REQ-016 SHALL increment tick_cnt on the same edge that sets tick.
REQ-017 SHALL, with PERIOD=1, hold tick high continuously for NUM_TICKS clocks.
REQ-018 SHALL, at edge k+NUM_TICKS*PERIOD, set tick=1, tick_cnt=NUM_TICKS, done=1 and busy=0 together.
REQ-019 SHALL hold DONE, with tick_cnt frozen, until start or abort.
REQ-020 SHALL, on start in DONE, restart exactly as from IDLE (REQ-013).
REQ-021 SHALL ignore start while in RUN.
REQ-022 SHALL, on abort in RUN or DONE, go to IDLE at the next edge, clear tick_cnt and prescaler, and issue no tick that edge.
REQ-023 SHALL give abort priority over start in the same cycle, and over a coincident final tick (no done asserted).
REQ-024 SHALL never wrap tick_cnt; it saturates at NUM_TICKS by construction.

Reset
REQ-025 SHALL, while reset=1, force state=IDLE, prescaler=0, tick=0, tick_cnt=0, busy=0, done=0, independent of clock.
REQ-026 SHALL, on reset asserted mid-RUN, abandon the run with no tick or done on deassertion; first start after release behaves per REQ-013.

Structure
REQ-027 SHALL take state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) from the shared package ts_tick_pkg.
REQ-028 SHALL place the prescaler in sub-module ts_prescaler (ports: clock, reset, clr, en, wrap).

Verification
REQ-029 SHALL cover default parameters, start pulse at edge 5: tick at edges 15/25/35/45, done and tick_cnt=4 at edge 45.
REQ-030 SHALL cover PERIOD=1, NUM_TICKS=3: tick high for edges k+1..k+3, done at k+3.
REQ-031 SHALL cover abort at edge k+25 (defaults): no further tick, tick_cnt=0, busy=0 at k+26.
REQ-032 SHALL cover start and abort high together in IDLE: the block stays IDLE and busy stays 0.
REQ-033 SHALL cover reset pulsed asynchronously mid-RUN: all outputs 0 immediately, then a clean rerun gives 4 ticks.
REQ-034 SHALL cover start in DONE: tick_cnt clears to 0 and a full second run completes.

Source files
------------

// File: rtl/ts_tick_pkg.sv
// Shared types for the tick sequencer.
// State encoding and prescaler width.
package ts_tick_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ts_state_e;

  localparam int unsigned PRE_W = 8;

endpackage

// File: rtl/ts_prescaler.sv
// Free-running divide-by-PERIOD counter.
// wrap flags the last count of each period while enabled.
module ts_prescaler
  import ts_tick_pkg::*;
#(
  parameter int PERIOD = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(PERIOD - 1);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  assign wrap = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ts_tick_sequencer.sv
// Issues NUM_TICKS ticks spaced PERIOD clocks apart per run.
// Abort wins over start and over a coincident final tick.
module ts_tick_sequencer
  import ts_tick_pkg::*;
#(
  parameter int PERIOD    = 10,
  parameter int NUM_TICKS = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             tick,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] NT = CNT_W'(NUM_TICKS);

  ts_state_e        state_q, state_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pre_clr;
  logic             pre_en;
  logic             pre_wrap;
  logic [CNT_W-1:0] cnt_inc;

  assign pre_en  = (state_q == RUN);
  assign cnt_inc = cnt_q + 1'b1;

  ts_prescaler #(
    .PERIOD(PERIOD)
  ) u_pre (
    .clock(clock),
    .reset(reset),
    .clr  (pre_clr),
    .en   (pre_en),
    .wrap (pre_wrap)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    pre_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!abort && start) begin
          state_d = RUN;
          cnt_d   = '0;
          pre_clr = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          pre_clr = 1'b1;
        end else if (pre_wrap) begin
          tick_d = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == NT) state_d = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          pre_clr = 1'b1;
        end else if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          pre_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pre_clr = 1'b1;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tick     = tick_q;
  assign tick_cnt = cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ts_tick_sequencer.sv
// Random and directed checks of two sequencer configurations
// against an elapsed-time reference model.
module tb_ts_tick_sequencer;

  localparam int P0 = 10;
  localparam int N0 = 4;
  localparam int P1 = 1;
  localparam int N1 = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       st0 = 1'b0, ab0 = 1'b0;
  logic       st1 = 1'b0, ab1 = 1'b0;
  logic       tick0, tick1, busy0, busy1, done0, done1;
  logic [7:0] cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  // model: mode 0 idle, 1 run, 2 done; e = clocks since start
  int m_mode[2];
  int m_e[2];
  int m_tick[2];
  int m_cnt[2];

  always #5 clock = ~clock;

  ts_tick_sequencer u_def (
    .clock(clock), .reset(reset), .start(st0), .abort(ab0),
    .tick(tick0), .tick_cnt(cnt0), .busy(busy0), .done(done0)
  );

  ts_tick_sequencer #(.PERIOD(P1), .NUM_TICKS(N1), .CNT_W(8)) u_p1 (
    .clock(clock), .reset(reset), .start(st1), .abort(ab1),
    .tick(tick1), .tick_cnt(cnt1), .busy(busy1), .done(done1)
  );

  task automatic chk(string tag, int unsigned got, int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_e[i] = 0; m_tick[i] = 0; m_cnt[i] = 0;
    end
  endfunction

  function automatic void m_step(int i, bit s, bit a, int p, int n);
    m_tick[i] = 0;
    if (a) begin
      m_mode[i] = 0; m_e[i] = 0; m_cnt[i] = 0;
    end else if (m_mode[i] == 1) begin
      m_e[i]++;
      m_tick[i] = (m_e[i] % p == 0);
      m_cnt[i]  = m_e[i] / p;
      if (m_e[i] == n * p) m_mode[i] = 2;
    end else if (s) begin
      m_mode[i] = 1; m_e[i] = 0; m_cnt[i] = 0;
    end
  endfunction

  task automatic check_all(string ph);
    chk({ph, ".tick0"}, tick0, m_tick[0]);
    chk({ph, ".cnt0"},  cnt0,  m_cnt[0]);
    chk({ph, ".busy0"}, busy0, m_mode[0] == 1);
    chk({ph, ".done0"}, done0, m_mode[0] == 2);
    chk({ph, ".tick1"}, tick1, m_tick[1]);
    chk({ph, ".cnt1"},  cnt1,  m_cnt[1]);
    chk({ph, ".busy1"}, busy1, m_mode[1] == 1);
    chk({ph, ".done1"}, done1, m_mode[1] == 2);
  endtask

  task automatic step(bit s0, bit a0, bit s1, bit a1);
    st0 = s0; ab0 = a0; st1 = s1; ab1 = a1;
    @(posedge clock);
    m_step(0, s0, a0, P0, N0);
    m_step(1, s1, a1, P1, N1);
    #1;
    check_all("cyc");
  endtask

  task automatic idle_steps(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("ar.tick0", tick0, 0);
    chk("ar.cnt0",  cnt0,  0);
    chk("ar.busy0", busy0, 0);
    chk("ar.done0", done0, 0);
    chk("ar.tick1", tick1, 0);
    chk("ar.busy1", busy1, 0);
    m_reset();
    #1 reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nt;
    m_reset();
    #2;
    check_all("rst");
    @(negedge clock);
    reset = 1'b0;

    // full default run, plus the PERIOD=1 run
    idle_steps(4);
    step(1, 0, 1, 0);
    for (int j = 1; j <= 45; j++) begin
      step(0, 0, 0, 0);
      chk("r29.tick", tick0, (j % 10 == 0) && (j <= 40));
      if (j == 40) begin
        chk("r29.cnt", cnt0, 4);
        chk("r29.done", done0, 1);
        chk("r29.busy", busy0, 0);
      end
      if (j <= 3) chk("r30.tick", tick1, 1);
      if (j == 3) chk("r30.done", done1, 1);
      if (j == 4) chk("r30.tick_end", tick1, 0);
    end

    // restart from DONE
    step(1, 0, 1, 0);
    chk("r34.cnt", cnt0, 0);
    chk("r34.busy", busy0, 1);
    idle_steps(40);
    chk("r34.done", done0, 1);
    chk("r34.cnt4", cnt0, 4);

    // abort mid-run; PERIOD=1 aborts on its final tick
    step(0, 1, 0, 1);
    step(1, 0, 1, 0);
    idle_steps(2);
    step(0, 0, 0, 1);
    chk("r23.done1", done1, 0);
    chk("r23.tick1", tick1, 0);
    idle_steps(22);
    step(0, 1, 0, 0);
    chk("r31.tick", tick0, 0);
    chk("r31.cnt", cnt0, 0);
    chk("r31.busy", busy0, 0);
    idle_steps(12);

    // start with abort in IDLE
    step(1, 1, 1, 1);
    chk("r32.busy0", busy0, 0);
    chk("r32.busy1", busy1, 0);

    // async reset mid-run, then a clean rerun
    step(1, 0, 1, 0);
    idle_steps(15);
    async_reset();
    idle_steps(3);
    step(1, 0, 1, 0);
    nt = 0;
    for (int j = 0; j < 45; j++) begin
      step(0, 0, 0, 0);
      if (tick0) nt++;
    end
    chk("r33.ticks", nt, 4);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 5) == 0, $urandom_range(0, 79) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
